instr_mem_loader: RTL and testbench

Write-side counterpart of the fetch-stage instruction register: accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide instruction memory, one byte per cycle, most significant byte at the lowest address (big-endian), at consecutive word addresses. The fetch stage then reads `Instr[PC]..Instr[PC+3]` back as `[31:24]..[7:0]`. It sits between the program-load source (test harness or boot streamer) and the write port of the instruction memory. The processor is held in reset while the loader is busy.

---
 rtl/instr_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes 32-bit instruction words into byte-wide instruction memory, big-endian.
// Latency: word accepted at edge k is written as bytes in cycles k+1..k+4; ready again in k+5.
// Backpressure: in_ready is high only in LOAD; the loader waits there indefinitely for in_valid.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, base_addr, - load command: word-aligned first byte address and word count
//   count, abort        (abort returns to IDLE from any busy state)
//   in_valid/in_ready - instruction word stream handshake, in_word carries the word
//   mem_we/mem_addr/  - byte write port of the instruction memory
//   mem_wdata
//   busy, done, err   - status: not idle, one-cycle completion pulse, sticky command error
module instr_mem_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTHI = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEPTHI-1:0] base_addr,
  input  logic [DEPTHI-2:0] count,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_word,
  output logic              mem_we,
  output logic [DEPTHI-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  // Memory size in bytes, expressed at the widened range-check width.
  localparam logic [DEPTHI+1:0] MEM_BYTES = {2'b01, {DEPTHI{1'b0}}};
  localparam logic [DEPTHI-1:0] ADDR_STEP = {{(DEPTHI-3){1'b0}}, 3'b100};
  localparam logic [DEPTHI-2:0] REM_ONE   = {{(DEPTHI-2){1'b0}}, 1'b1};

  state_t            state_q;
  logic [DEPTHI-1:0] addr_q;
  logic [DEPTHI-2:0] rem_q;
  logic [1:0]        beat_q;
  logic [WIDTH-1:0]  word_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [DEPTHI-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [DEPTHI+1:0] cmd_end_d;
  logic [1:0]        beat_d;

  // Big-endian byte lane: beat 0 carries the most significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // End address of the requested region, two bits wider so that a region
  // running past the top of memory is caught instead of wrapping to 0.
  always_comb begin
    cmd_end_d = {2'b00, base_addr} + {1'b0, count, 2'b00};
    beat_d    = beat_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // start has priority over abort here simply because abort is not looked at in IDLE.
          if (start) begin
            if (base_addr[1:0] != 2'b00) begin
              err_q <= 1'b1;
            end else if (cmd_end_d > MEM_BYTES) begin
              err_q <= 1'b1;
            end else if (count == '0) begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q      <= 1'b0;
              addr_q     <= base_addr;
              rem_q      <= count;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (abort) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (in_valid) begin
            // Beat 0 is presented straight from the accepted word.
            word_q      <= in_word;
            beat_q      <= 2'd0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= in_word[31:24];
            state_q     <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The byte on the port this cycle is written regardless of abort;
          // abort only stops the following beats.
          if (abort) begin
            mem_we_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (beat_q == 2'd3) begin
            mem_we_q <= 1'b0;
            addr_q   <= addr_q + ADDR_STEP;
            rem_q    <= rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end else begin
            // addr_q is word-aligned, so the beat fills the low two bits.
            beat_q      <= beat_d;
            mem_addr_q  <= {addr_q[DEPTHI-1:2], beat_d};
            mem_wdata_q <= byte_sel(word_q[31:0], beat_d);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized loads against an address/byte/cycle reference model.
// Latency: n/a (testbench).
// Backpressure: in_valid is driven with random gaps to exercise the LOAD wait.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [15:0] base_addr;
  logic [14:0] count;
  logic [31:0] in_word;
  logic        in_ready, mem_we, busy, done, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Observed activity
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  // Stimulus record and model expectations
  int          hs_q[$];
  logic [31:0] words_q[$];
  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  int          exp_cyc_q[$];

  instr_mem_loader #(.WIDTH(32), .DEPTHI(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); hs_q.delete();
  endtask

  // Start is sampled at the edge inside this task; c0 is the cycle right after it.
  task automatic issue_start(input logic [15:0] b, input logic [14:0] n, output int c0);
    base_addr = b; count = n; start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  // Feeds words_q with random valid gaps until the loader goes idle; records handshake cycles.
  task automatic run_words(input int gap_max, output bit timed_out);
    int idx = 0;
    int budget = 2000;
    while (busy && budget > 0) begin
      if (idx < words_q.size()) begin
        in_valid = ($urandom_range(0, gap_max) == 0);
        in_word  = words_q[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        idx++;
      end
      tick();
      budget--;
    end
    in_valid = 1'b0;
    timed_out = busy;
  endtask

  task automatic wait_idle(output bit timed_out);
    int budget = 200;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    timed_out = busy;
  endtask

  // Reference: word i lands at b+4i..b+4i+3, MSB first, one byte per cycle after its handshake.
  function automatic void build_model(input logic [15:0] b, input int nwords);
    int n = (nwords < hs_q.size()) ? nwords : hs_q.size();
    exp_addr_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        exp_addr_q.push_back(b + 16'(4 * i + j));
        exp_data_q.push_back(8'(words_q[i] >> (24 - 8 * j)));
        exp_cyc_q.push_back(hs_q[i] + 1 + j);
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err} !== 29'd0) begin
      fails++;
      $display("FAIL reset outputs: got rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_word();
    int c0;
    bit to;
    clear_logs();
    words_q = '{32'h20010005, 32'h8C220004};
    issue_start(16'h0010, 15'd2, c0);
    run_words(0, to);
    build_model(16'h0010, 2);
    checks++;
    if (to || hs_q.size() != 2 || hs_q[0] != c0 || hs_q[1] != c0 + 5) begin
      fails++;
      $display("FAIL two_word handshakes: got n=%0d timeout=%0b want 2 at cycles 1 and 6", hs_q.size(), to);
    end
    checks++;
    if (wr_addr_q.size() != exp_addr_q.size()) begin
      fails++;
      $display("FAIL two_word write count: got %0d want %0d", wr_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
          fails++;
          $display("FAIL two_word byte %0d: got %h=%h@%0d want %h=%h@%0d", i, wr_addr_q[i], wr_data_q[i],
                   wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != c0 + 10) begin
      fails++;
      $display("FAIL two_word done: got %0d pulses want 1 in cycle 11", done_cyc_q.size());
    end
  endtask

  task automatic test_backpressure();
    int c0;
    bit to;
    logic [15:0] b = 16'(4 * $urandom_range(0, 1000));
    logic [31:0] w = $urandom;
    clear_logs();
    words_q = '{w};
    issue_start(b, 15'd1, c0);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (in_ready !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL backpressure wait %0d: got rdy=%b we=%b busy=%b want 1 0 1", i, in_ready, mem_we, busy);
      end
      tick();
    end
    in_valid = 1'b1; in_word = w;
    hs_q.push_back(cyc);
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== b || mem_wdata !== w[31:24]) begin
      fails++;
      $display("FAIL backpressure first byte: got we=%b %h=%h want 1 %h=%h", mem_we, mem_addr, mem_wdata, b, w[31:24]);
    end
    wait_idle(to);
    build_model(b, 1);
    checks++;
    if (to || wr_addr_q.size() != 4) begin
      fails++;
      $display("FAIL backpressure write count: got %0d timeout=%0b want 4", wr_addr_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
          fails++;
          $display("FAIL backpressure byte %0d: got %h=%h@%0d want %h=%h@%0d", i, wr_addr_q[i], wr_data_q[i],
                   wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_rejected();
    int c0;
    int k = $urandom_range(0, 7);
    clear_logs();
    issue_start(16'h0002, 15'd1, c0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reject misaligned: got err=%b busy=%b rdy=%b want 1 0 0", err, busy, in_ready);
    end
    tick(); tick();
    issue_start(16'hFFFC, 15'd2, c0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reject overflow: got err=%b busy=%b want 1 0", err, busy);
    end
    // Region overruns the top of memory by exactly one word.
    issue_start(16'hFFFC - 16'(4 * k), 15'(k + 2), c0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reject overflow k=%0d: got err=%b busy=%b want 1 0", k, err, busy);
    end
    tick(); tick(); tick();
    checks++;
    if (wr_addr_q.size() != 0 || done_cyc_q.size() != 0 || err !== 1'b1) begin
      fails++;
      $display("FAIL reject side effects: got %0d writes %0d dones err=%b want 0 0 1",
               wr_addr_q.size(), done_cyc_q.size(), err);
    end
    issue_start(16'h0040, 15'd0, c0);
    checks++;
    if (err !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL reject clear: got err=%b done=%b want 0 1", err, done);
    end
    tick(); tick();
  endtask

  task automatic test_top_fit();
    int c0;
    bit to;
    bit hit_zero = 0;
    clear_logs();
    words_q = '{32'hDEADBEEF};
    issue_start(16'hFFFC, 15'd1, c0);
    run_words(0, to);
    tick();
    build_model(16'hFFFC, 1);
    checks++;
    if (to || wr_addr_q.size() != 4) begin
      fails++;
      $display("FAIL top_fit write count: got %0d timeout=%0b want 4", wr_addr_q.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
          fails++;
          $display("FAIL top_fit byte %0d: got %h=%h want %h=%h", i, wr_addr_q[i], wr_data_q[i],
                   exp_addr_q[i], exp_data_q[i]);
        end
      end
    end
    foreach (wr_addr_q[i]) if (wr_addr_q[i] == 16'h0000) hit_zero = 1;
    checks++;
    if (hit_zero || done_cyc_q.size() != 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL top_fit wrap/done: got wrote0=%0b dones=%0d err=%b want 0 1 0", hit_zero, done_cyc_q.size(), err);
    end
  endtask

  task automatic test_abort();
    int c0;
    bit to;
    logic [15:0] b = 16'(4 * $urandom_range(0, 1000));
    logic [31:0] w = $urandom;
    clear_logs();
    issue_start(b, 15'd2, c0);
    in_valid = 1'b1; in_word = w;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== b + 16'd1) begin
      fails++;
      $display("FAIL abort beat1 position: got we=%b addr=%h want 1 %h", mem_we, mem_addr, b + 16'd1);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL abort idle: got busy=%b we=%b want 0 0", busy, mem_we);
    end
    repeat (5) tick();
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== b || wr_data_q[0] !== w[31:24] ||
        wr_addr_q[1] !== b + 16'd1 || wr_data_q[1] !== w[23:16] || done_cyc_q.size() != 0 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort writes: got %0d writes %0d dones err=%b want 2 bytes %h %h, 0 dones, err 0",
               wr_addr_q.size(), done_cyc_q.size(), err, w[31:24], w[23:16]);
    end
    // A fresh load after abort behaves normally.
    clear_logs();
    b = 16'(4 * $urandom_range(0, 1000));
    words_q = '{$urandom, $urandom};
    issue_start(b, 15'd2, c0);
    run_words(1, to);
    build_model(b, 2);
    checks++;
    if (to || wr_addr_q.size() != 8 || done_cyc_q.size() != 1) begin
      fails++;
      $display("FAIL after_abort load: got %0d writes %0d dones timeout=%0b want 8 1 0",
               wr_addr_q.size(), done_cyc_q.size(), to);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
          fails++;
          $display("FAIL after_abort byte %0d: got %h=%h@%0d want %h=%h@%0d", i, wr_addr_q[i], wr_data_q[i],
                   wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_and_restart();
    int c0;
    int idx = 0;
    logic [15:0] b = 16'(4 * $urandom_range(0, 1000));
    clear_logs();
    issue_start(b, 15'd0, c0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL zero_count cycle1: got done=%b busy=%b want 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() != 0) begin
      fails++;
      $display("FAIL zero_count cycle2: got done=%b busy=%b writes=%0d want 0 0 0", done, busy, wr_addr_q.size());
    end
    // Second load: a misaligned start lands during WRITE and must be ignored entirely.
    clear_logs();
    words_q = '{$urandom, $urandom};
    issue_start(b, 15'd2, c0);
    for (int n = 0; n < 40 && busy; n++) begin
      in_valid = (idx < 2);
      in_word  = (idx < 2) ? words_q[idx] : 32'd0;
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        idx++;
      end
      start     = (n == 2);
      base_addr = 16'h0002;
      count     = 15'd5;
      tick();
    end
    in_valid = 1'b0; start = 1'b0;
    build_model(b, 2);
    checks++;
    if (busy || wr_addr_q.size() != 8 || done_cyc_q.size() != 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL restart ignored: got %0d writes %0d dones err=%b busy=%b want 8 1 0 0",
               wr_addr_q.size(), done_cyc_q.size(), err, busy);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
          fails++;
          $display("FAIL restart byte %0d: got %h=%h@%0d want %h=%h@%0d", i, wr_addr_q[i], wr_data_q[i],
                   wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      int c0;
      bit to;
      int n = $urandom_range(1, 5);
      logic [15:0] b = 16'(4 * $urandom_range(0, 16384 - n));
      clear_logs();
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      issue_start(b, 15'(n), c0);
      run_words($urandom_range(0, 3), to);
      build_model(b, n);
      checks++;
      if (to || hs_q.size() != n || wr_addr_q.size() != exp_addr_q.size()) begin
        fails++;
        $display("FAIL random load %0d: got %0d writes %0d handshakes timeout=%0b want %0d %0d 0",
                 t, wr_addr_q.size(), hs_q.size(), to, 4 * n, n);
      end else begin
        for (int i = 0; i < exp_addr_q.size(); i++) begin
          checks++;
          if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i] || wr_cyc_q[i] !== exp_cyc_q[i]) begin
            fails++;
            $display("FAIL random load %0d byte %0d: got %h=%h@%0d want %h=%h@%0d", t, i, wr_addr_q[i],
                     wr_data_q[i], wr_cyc_q[i], exp_addr_q[i], exp_data_q[i], exp_cyc_q[i]);
          end
        end
        checks++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != hs_q[n-1] + 5) begin
          fails++;
          $display("FAIL random load %0d done: got %0d pulses want 1 at cycle %0d", t, done_cyc_q.size(), hs_q[n-1] + 5);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    clear_logs();
    issue_start(16'h0100, 15'd3, c0);
    in_valid = 1'b1; in_word = $urandom;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err} !== 29'd0) begin
      fails++;
      $display("FAIL reset_mid outputs: got rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b want all 0",
               in_ready, mem_we, mem_addr, mem_wdata, busy, done, err);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 2 || done_cyc_q.size() != 0) begin
      fails++;
      $display("FAIL reset_mid aftermath: got busy=%b writes=%0d dones=%0d want 0 2 0",
               busy, wr_addr_q.size(), done_cyc_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; count = '0; in_word = '0;
    test_reset();
    test_two_word();
    test_backpressure();
    test_rejected();
    test_top_fit();
    test_abort();
    test_zero_and_restart();
    test_random_loads();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
